// File: rtl/cla_slice_seq_adder.sv
// cla_slice_seq_adder: multi-cycle WIDTH-bit adder/subtractor built around a
// single 4-bit carry-lookahead slice. One slice is processed per clock,
// least-significant first, with a registered carry linking the slices.
// Operands shift right by one nibble per slice, and partial sums shift in
// from the top, so no variable part-selects are needed.

module cla_slice_seq_adder #(
   parameter  int WIDTH  = 12,
   localparam int NSLICE = WIDTH / 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   input  logic             sub,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   result,
   output logic             ovf,
   output logic             zero
);

   localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // 4-bit carry-lookahead slice; returns {c4, s[3:0]}.
   function automatic logic [4:0] cla4(input logic [3:0] a,
                                       input logic [3:0] b,
                                       input logic       c0);
      logic [3:0] p;
      logic [3:0] g;
      logic [4:0] c;
      p    = a ^ b;
      g    = a & b;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c[4], p ^ c[3:0]};
   endfunction

   state_t           state_q,  state_d;
   logic [IW-1:0]    idx_q,    idx_d;
   logic             carry_q,  carry_d;
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   logic             a_msb_q,  a_msb_d;
   logic             b_msb_q,  b_msb_d;
   logic [WIDTH-1:0] sum_q,    sum_d;
   logic [WIDTH:0]   result_q, result_d;
   logic             ovf_q,    ovf_d;
   logic             zero_q,   zero_d;
   logic             done_q,   done_d;
   logic             ready_q,  ready_d;
   logic             busy_q,   busy_d;

   logic [4:0]       slice_s;
   logic [WIDTH-1:0] sum_next_s;
   logic [WIDTH-1:0] b_eff_s;

   // Next-state, datapath and output-flag computation for the slice sequencer.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      carry_d    = carry_q;
      a_d        = a_q;
      b_d        = b_q;
      a_msb_d    = a_msb_q;
      b_msb_d    = b_msb_q;
      sum_d      = sum_q;
      result_d   = result_q;
      ovf_d      = ovf_q;
      zero_d     = zero_q;
      slice_s    = cla4(a_q[3:0], b_q[3:0], carry_q);
      sum_next_s = {slice_s[3:0], sum_q[WIDTH-1:4]};
      b_eff_s    = sub ? ~op_b : op_b;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d     = op_a;
               b_d     = b_eff_s;
               a_msb_d = op_a[WIDTH-1];
               b_msb_d = b_eff_s[WIDTH-1];
               carry_d = sub ? 1'b1 : cin;
               idx_d   = {IW{1'b0}};
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            a_d     = {4'b0000, a_q[WIDTH-1:4]};
            b_d     = {4'b0000, b_q[WIDTH-1:4]};
            carry_d = slice_s[4];
            sum_d   = sum_next_s;
            if (idx_q == LAST_IDX) begin
               idx_d    = {IW{1'b0}};
               state_d  = S_DONE;
               result_d = {slice_s[4], sum_next_s};
               ovf_d    = (a_msb_q == b_msb_q) && (sum_next_s[WIDTH-1] != a_msb_q);
               zero_d   = (sum_next_s == {WIDTH{1'b0}});
            end else begin
               idx_d    = idx_q + IW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      done_d  = (state_d == S_DONE);
      ready_d = (state_d != S_RUN);
      busy_d  = (state_d == S_RUN);
   end

   // State, datapath and registered-output flops with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= {IW{1'b0}};
         carry_q  <= 1'b0;
         a_q      <= {WIDTH{1'b0}};
         b_q      <= {WIDTH{1'b0}};
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         sum_q    <= {WIDTH{1'b0}};
         result_q <= {(WIDTH+1){1'b0}};
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         sum_q    <= sum_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign ready  = ready_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign ovf    = ovf_q;
   assign zero   = zero_q;

   cla_slice_seq_adder_chk u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .ready (ready_q),
      .busy  (busy_q),
      .done  (done_q)
   );

endmodule

// Handshake invariants for cla_slice_seq_adder.
module cla_slice_seq_adder_chk (
   input logic clk,
   input logic rst_n,
   input logic ready,
   input logic busy,
   input logic done
);

   a_ready_busy_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(ready && busy));

   a_done_ready: assert property (@(posedge clk) disable iff (!rst_n)
      done |-> ready);

endmodule
